// File: rtl/matrix_accel_soc.sv
// Matrix accelerator demo SoC: a 64-bit word RAM, a UART (8N1) command bridge and a
// lane-wise 32-bit multiply engine, all on a single clock domain.

module matrix_dram #(
    parameter int DW    = 64,
    parameter int WORDS = 8192,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] init_val [0:WORDS-1];
    logic [DW-1:0] rdata_q;

    // Single-port RAM with one-cycle registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            init_val[addr] <= wdata;
        end
        rdata_q <= init_val[addr];
    end

    assign rdata = rdata_q;
endmodule

module matrix_accel_soc #(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] RAM_BASE       = 32'h8000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] RAM_LENGTH     = 32'h0001_0000,
    parameter int                        CLKS_PER_BIT   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tx,
    input  logic rx
);
    localparam int          WORDS     = int'(RAM_LENGTH >> 3);
    localparam int          AW        = $clog2(WORDS);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  OP_W = 8'h57, OP_R = 8'h52, OP_M = 8'h4D;
    localparam logic [7:0]  RSP_K = 8'h4B, RSP_D = 8'h44, RSP_E = 8'h45;
    localparam logic [3:0]  S_IDLE = 4'd0, S_ARGS = 4'd1, S_EXEC = 4'd2, S_RDW = 4'd3,
                            S_RESP = 4'd4, S_RDA = 4'd5, S_RDB = 4'd6, S_WRC = 4'd7,
                            S_DONE = 4'd8;

    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >= RAM_BASE) && (a < RAM_BASE + RAM_LENGTH) && (a[2:0] == 3'd0);
    endfunction

    // n must be non-zero: checks the first and the last word of an n-word run.
    function automatic logic range_ok(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] n);
        logic [AXI_ADDR_WIDTH-1:0] last;
        last = a + ({{(AXI_ADDR_WIDTH-8){1'b0}}, n - 8'd1} << 3);
        return addr_ok(a) && addr_ok(last);
    endfunction

    function automatic logic [AW-1:0] widx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return AW'((a - RAM_BASE) >> 3);
    endfunction

    // The low 32 bits of a product are identical for signed and unsigned operands.
    function automatic logic [31:0] lane_mul(input logic [31:0] x, input logic [31:0] y);
        return x * y;
    endfunction

    logic        rx_meta_q, rx_sync_q, rx_busy_q, rx_busy_d, rx_valid_q, rx_valid_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic [9:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  fifo_q [0:15];
    logic [4:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic        fifo_full_s, fifo_empty_s, push_s, pop_s, accept_s, ram_we_s;
    logic [3:0]  st_q, st_d, argc_q, argc_d, rspn_q, rspn_d, need_s;
    logic [7:0]  op_q, op_d, k_q, k_d, n_s;
    logic [103:0] arg_q, arg_d;
    logic [63:0] a_lat_q, a_lat_d, rsp_q, rsp_d, ram_wdata_s, ram_rdata_s;
    logic [AXI_ADDR_WIDTH-1:0] a_addr_s, b_addr_s, c_addr_s;
    logic [AW-1:0] ram_addr_s;

    assign fifo_full_s  = (wptr_q - rptr_q) == 5'd16;
    assign fifo_empty_s = wptr_q == rptr_q;
    assign accept_s     = rx_valid_q && !fifo_full_s;
    assign a_addr_s     = arg_q[31:0];
    assign b_addr_s     = arg_q[63:32];
    assign c_addr_s     = arg_q[95:64];
    assign n_s          = arg_q[103:96];
    assign need_s       = (op_q == OP_W) ? 4'd12 : ((op_q == OP_R) ? 4'd4 : 4'd13);
    assign tx           = tx_q;

    // UART receiver: mid-bit sampling; a low stop bit drops the byte.
    always_comb begin
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        if (!rx_busy_q) begin
            if (!rx_sync_q) begin
                rx_busy_d = 1'b1;
                rx_cnt_d  = HALF_LAST;
                rx_bit_d  = 4'd0;
            end else begin
                rx_cnt_d = rx_cnt_q;
            end
        end else if (rx_cnt_q != 16'd0) begin
            rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
            rx_cnt_d = BIT_LAST;
            if (rx_bit_q == 4'd0) begin
                rx_busy_d = !rx_sync_q;
                rx_bit_d  = 4'd1;
            end else if (rx_bit_q < 4'd9) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 4'd1;
            end else begin
                rx_busy_d  = 1'b0;
                rx_valid_d = rx_sync_q;
            end
        end
    end

    // UART transmitter fed from the response FIFO.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop_s      = 1'b0;
        if (!tx_busy_q) begin
            if (!fifo_empty_s) begin
                pop_s      = 1'b1;
                tx_busy_d  = 1'b1;
                tx_shift_d = {1'b1, fifo_q[rptr_q[3:0]], 1'b0};
                tx_bit_d   = 4'd10;
                tx_cnt_d   = BIT_LAST;
            end else begin
                tx_busy_d = 1'b0;
            end
        end else if (tx_cnt_q != 16'd0) begin
            tx_cnt_d = tx_cnt_q - 16'd1;
        end else if (tx_bit_q == 4'd1) begin
            tx_busy_d = 1'b0;
        end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q - 4'd1;
            tx_cnt_d   = BIT_LAST;
        end
        tx_d   = tx_busy_q ? tx_shift_q[0] : 1'b1;
        rptr_d = pop_s ? rptr_q + 5'd1 : rptr_q;
        wptr_d = push_s ? wptr_q + 5'd1 : wptr_q;
    end

    // Command parser and multiply engine; the engine owns the RAM port in RDA..WRC.
    always_comb begin
        st_d        = st_q;
        op_d        = op_q;
        arg_d       = arg_q;
        argc_d      = argc_q;
        k_d         = k_q;
        a_lat_d     = a_lat_q;
        rsp_d       = rsp_q;
        rspn_d      = rspn_q;
        push_s      = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = widx(a_addr_s);
        ram_wdata_s = arg_q[95:32];
        case (st_q)
            S_IDLE: begin
                if (accept_s && (rx_shift_q == OP_W || rx_shift_q == OP_R || rx_shift_q == OP_M)) begin
                    op_d   = rx_shift_q;
                    argc_d = 4'd0;
                    st_d   = S_ARGS;
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_ARGS: begin
                if (accept_s) begin
                    arg_d[{argc_q, 3'b000} +: 8] = rx_shift_q;
                    argc_d = argc_q + 4'd1;
                    st_d   = (argc_q + 4'd1 == need_s) ? S_EXEC : S_ARGS;
                end else begin
                    st_d = S_ARGS;
                end
            end
            S_EXEC: begin
                rspn_d = 4'd1;
                rsp_d  = {56'd0, RSP_E};
                st_d   = S_RESP;
                if (op_q == OP_W) begin
                    if (addr_ok(a_addr_s)) begin
                        ram_we_s = 1'b1;
                        rsp_d    = {56'd0, RSP_K};
                    end else begin
                        ram_we_s = 1'b0;
                    end
                end else if (op_q == OP_R) begin
                    st_d = addr_ok(a_addr_s) ? S_RDW : S_RESP;
                end else if (n_s == 8'd0) begin
                    st_d = S_DONE;
                end else if (range_ok(a_addr_s, n_s) && range_ok(b_addr_s, n_s) && range_ok(c_addr_s, n_s)) begin
                    k_d  = 8'd0;
                    st_d = S_RDA;
                end else begin
                    st_d = S_RESP;
                end
            end
            S_RDW: begin
                rsp_d  = ram_rdata_s;
                rspn_d = 4'd8;
                st_d   = S_RESP;
            end
            S_RESP: begin
                if (!fifo_full_s) begin
                    push_s = 1'b1;
                    rsp_d  = rsp_q >> 8;
                    rspn_d = rspn_q - 4'd1;
                    st_d   = (rspn_q == 4'd1) ? S_IDLE : S_RESP;
                end else begin
                    st_d = S_RESP;
                end
            end
            S_RDA: begin
                ram_addr_s = widx(a_addr_s) + AW'(k_q);
                st_d       = S_RDB;
            end
            S_RDB: begin
                ram_addr_s = widx(b_addr_s) + AW'(k_q);
                a_lat_d    = ram_rdata_s;
                st_d       = S_WRC;
            end
            S_WRC: begin
                ram_addr_s  = widx(c_addr_s) + AW'(k_q);
                ram_we_s    = 1'b1;
                ram_wdata_s = {lane_mul(a_lat_q[63:32], ram_rdata_s[63:32]),
                               lane_mul(a_lat_q[31:0], ram_rdata_s[31:0])};
                k_d         = k_q + 8'd1;
                st_d        = (k_q + 8'd1 < n_s) ? S_RDA : S_DONE;
            end
            S_DONE: begin
                rsp_d  = {56'd0, RSP_D};
                rspn_d = 4'd1;
                st_d   = S_RESP;
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    // Response FIFO storage; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wptr_q[3:0]] <= rsp_q[7:0];
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;   rx_sync_q  <= 1'b1;   rx_busy_q <= 1'b0;
            rx_cnt_q  <= 16'd0;  rx_bit_q   <= 4'd0;   rx_shift_q <= 8'd0;
            rx_valid_q <= 1'b0;  tx_q       <= 1'b1;   tx_busy_q <= 1'b0;
            tx_cnt_q  <= 16'd0;  tx_bit_q   <= 4'd0;   tx_shift_q <= 10'h3FF;
            wptr_q    <= 5'd0;   rptr_q     <= 5'd0;   st_q      <= S_IDLE;
            op_q      <= 8'd0;   arg_q      <= 104'd0; argc_q    <= 4'd0;
            k_q       <= 8'd0;   a_lat_q    <= 64'd0;  rsp_q     <= 64'd0;
            rspn_q    <= 4'd0;
        end else begin
            rx_meta_q <= rx;        rx_sync_q  <= rx_meta_q;  rx_busy_q <= rx_busy_d;
            rx_cnt_q  <= rx_cnt_d;  rx_bit_q   <= rx_bit_d;   rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d; tx_q     <= tx_d;       tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;  tx_bit_q   <= tx_bit_d;   tx_shift_q <= tx_shift_d;
            wptr_q    <= wptr_d;    rptr_q     <= rptr_d;     st_q      <= st_d;
            op_q      <= op_d;      arg_q      <= arg_d;      argc_q    <= argc_d;
            k_q       <= k_d;       a_lat_q    <= a_lat_d;    rsp_q     <= rsp_d;
            rspn_q    <= rspn_d;
        end
    end

    matrix_dram #(
        .DW    (AXI_DATA_WIDTH),
        .WORDS (WORDS),
        .AW    (AW)
    ) i_dram (
        .clk   (clk),
        .we    (ram_we_s && !rst),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );
endmodule

// File: tb/tb_matrix_accel_soc.sv
// Directed bench for matrix_accel_soc: drives UART commands on rx, decodes tx
// independently and compares against hand-computed replies and RAM contents.

module tb_matrix_accel_soc;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int checks = 0;
    int errors = 0;
    int frame_errs = 0;
    logic [7:0] rxq [$];

    typedef struct {
        string        name;
        logic [7:0]   op;
        logic [103:0] args;
        int           nargs;
        logic [63:0]  rsp;
        int           nrsp;
    } vec_t;
    vec_t vq [$];

    matrix_accel_soc dut (.clk(clk), .rst(rst), .tx(tx), .rx(rx));

    always #5 clk = ~clk;

    // Decode every byte leaving tx, sampling mid-bit on the falling clock edge.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) frame_errs++;
                rxq.push_back(b);
            end
        end
    end

    function automatic logic [103:0] rd(input logic [31:0] a);
        return {72'd0, a};
    endfunction
    function automatic logic [103:0] wr(input logic [31:0] a, input logic [63:0] d);
        return {8'd0, d, a};
    endfunction
    function automatic logic [103:0] mm(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [7:0] n);
        return {n, c, b, a};
    endfunction

    task automatic add_vec(input string nm, input logic [7:0] op, input logic [103:0] args,
                           input int nargs, input logic [63:0] rsp, input int nrsp);
        vec_t v;
        v.name = nm; v.op = op; v.args = args; v.nargs = nargs; v.rsp = rsp; v.nrsp = nrsp;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] exp);
        int t;
        t = 0;
        while (rxq.size() == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (rxq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no byte on tx within timeout, expected %h", nm, exp);
        end else begin
            chk(nm, {56'd0, rxq.pop_front()}, {56'd0, exp});
        end
    endtask

    task automatic expect_quiet(input string nm, input int cyc);
        repeat (cyc) @(negedge clk);
        chk({nm, "_no_extra_bytes"}, 64'(rxq.size()), 64'd0);
        rxq.delete();
    endtask

    task automatic run_vec(input vec_t v);
        send_byte(v.op);
        for (int i = 0; i < v.nargs; i++) send_byte(v.args[i*8 +: 8]);
        for (int i = 0; i < v.nrsp; i++) expect_byte(v.name, v.rsp[i*8 +: 8]);
        expect_quiet(v.name, 240);
    endtask

    initial begin
        int hi_err;

        add_vec("rd_preload",  8'h52, rd(32'h8000_0000), 4, 64'h0123_4567_89AB_CDEF, 8);
        add_vec("wr_word",     8'h57, wr(32'h8000_0008, 64'hDEAD_BEEF_0000_0001), 12, 64'h4B, 1);
        add_vec("rd_back",     8'h52, rd(32'h8000_0008), 4, 64'hDEAD_BEEF_0000_0001, 8);
        add_vec("mul_n1",      8'h4D, mm(32'h8000_0100, 32'h8000_0200, 32'h8000_0300, 8'd1), 13, 64'h44, 1);
        add_vec("rd_mul_n1",   8'h52, rd(32'h8000_0300), 4, {32'hFFFF_FFF6, 32'd21}, 8);
        add_vec("rd_below",    8'h52, rd(32'h7FFF_FFF8), 4, 64'h45, 1);
        add_vec("wr_above",    8'h57, wr(32'h8001_0000, 64'h0), 12, 64'h45, 1);
        add_vec("mul_n0",      8'h4D, mm(32'h8000_0100, 32'h8000_0200, 32'h8000_0300, 8'd0), 13, 64'h44, 1);
        add_vec("rd_misalign", 8'h52, rd(32'h8000_0004), 4, 64'h45, 1);
        add_vec("mul_c_range", 8'h4D, mm(32'h8000_0100, 32'h8000_0200, 32'h8000_FFF8, 8'd2), 13, 64'h45, 1);
        add_vec("rd_top_word", 8'h52, rd(32'h8000_FFF8), 4, 64'hA5A5_5A5A_C3C3_3C3C, 8);
        add_vec("mul_n2",      8'h4D, mm(32'h8000_0400, 32'h8000_0480, 32'h8000_0500, 8'd2), 13, 64'h44, 1);
        add_vec("rd_c0",       8'h52, rd(32'h8000_0500), 4, 64'hFFFF_FFFE_0000_0000, 8);
        add_vec("rd_c1",       8'h52, rd(32'h8000_0508), 4, 64'h0000_0001_FFFF_FFF4, 8);
        add_vec("mul_inplace", 8'h4D, mm(32'h8000_0100, 32'h8000_0100, 32'h8000_0100, 8'd1), 13, 64'h44, 1);
        add_vec("rd_inplace",  8'h52, rd(32'h8000_0100), 4, 64'h0000_0004_0000_0009, 8);

        repeat (2) @(negedge clk);
        dut.i_dram.init_val[0]    = 64'h0123_4567_89AB_CDEF;
        dut.i_dram.init_val[1]    = 64'h5555_AAAA_5555_AAAA;
        dut.i_dram.init_val[2]    = 64'h0;
        dut.i_dram.init_val[32]   = {32'hFFFF_FFFE, 32'd3};
        dut.i_dram.init_val[64]   = {32'd5, 32'd7};
        dut.i_dram.init_val[96]   = 64'hFFFF_FFFF_FFFF_FFFF;
        dut.i_dram.init_val[128]  = {32'h7FFF_FFFF, 32'd2};
        dut.i_dram.init_val[129]  = 64'hFFFF_FFFF_FFFF_FFFD;
        dut.i_dram.init_val[144]  = {32'd2, 32'h8000_0000};
        dut.i_dram.init_val[145]  = 64'hFFFF_FFFF_0000_0004;
        dut.i_dram.init_val[8191] = 64'hA5A5_5A5A_C3C3_3C3C;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_high", {63'd0, tx}, 64'd1);

        // Idle line for 10k cycles: nothing transmitted, RAM untouched.
        hi_err = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) hi_err++;
        end
        chk("idle_tx_low_cycles", 64'(hi_err), 64'd0);
        chk("idle_tx_bytes", 64'(rxq.size()), 64'd0);
        chk("idle_ram_w1", dut.i_dram.init_val[1], 64'h5555_AAAA_5555_AAAA);

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

        chk("ram_w0_after_errors", dut.i_dram.init_val[0], 64'h0123_4567_89AB_CDEF);
        chk("ram_c1_backdoor", dut.i_dram.init_val[161], 64'h0000_0001_FFFF_FFF4);

        // Unknown opcodes are dropped and the parser stays idle.
        send_byte(8'h00);
        send_byte(8'hFF);
        run_vec(vq[0]);

        // Reset in the middle of a 'W' frame, then a clean 'W'.
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h80);
        send_byte(8'hCA);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midframe_reset_tx_high", {63'd0, tx}, 64'd1);
        send_byte(8'h57);
        for (int i = 0; i < 12; i++) begin
            logic [103:0] a;
            a = wr(32'h8000_0010, 64'hCAFE_F00D_1234_5678);
            send_byte(a[i*8 +: 8]);
        end
        expect_byte("wr_after_reset", 8'h4B);
        expect_quiet("wr_after_reset", 240);
        chk("wr_after_reset_ram", dut.i_dram.init_val[2], 64'hCAFE_F00D_1234_5678);

        chk("tx_stop_bits", 64'(frame_errs), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
